// File: rtl/mul_arbiter_ctrl.sv
// mul_arbiter_ctrl
// Shares one external 4x4 shift-add multiplier between two requesters.
// Grants round-robin, pulses the multiplier load strobe with the winner's
// operands, waits MUL_CYCLES iteration cycles, captures the 8-bit product and
// returns it to the winner with a one-cycle done pulse.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   req0, a0, b0    requester 0 request and operands (held until done0)
//   req1, a1, b1    requester 1 request and operands (held until done1)
//   done0, done1    one-cycle result-valid pulses
//   res             last captured product, held until the next capture
//   busy            high whenever a job is in flight
//   mul_ld          load strobe to the multiplier
//   mul_a, mul_b    operands to the multiplier (zero outside the load cycle)
//   mul_y           product from the multiplier
module mul_arbiter_ctrl #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] res,
    output logic       busy,
    output logic       mul_ld,
    output logic [3:0] mul_a,
    output logic [3:0] mul_b,
    input  logic [7:0] mul_y
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StCap} state_e;

    // Last RUN cycle count; cnt starts at 0 in the first RUN cycle.
    localparam logic [3:0] CntLast = 4'(MUL_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] op_a_q, op_a_d;
    logic [3:0] op_b_q, op_b_d;
    logic       gnt_q, gnt_d;
    logic       last_grant_q, last_grant_d;
    logic [3:0] cnt_q, cnt_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic [7:0] res_q, res_d;
    logic       mul_ld_q, mul_ld_d;
    logic [3:0] mul_a_q, mul_a_d;
    logic [3:0] mul_b_q, mul_b_d;

    logic elig0, elig1, grant_valid, grant_sel;

    // A requester still holding req during its own done cycle is not eligible;
    // that keeps a finished job from being granted again immediately.
    always_comb begin
        elig0       = req0 & ~done0_q;
        elig1       = req1 & ~done1_q;
        grant_valid = elig0 | elig1;
        grant_sel   = (elig0 & elig1) ? ~last_grant_q : elig1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (grant_valid) state_d = StLoad;
            StLoad: state_d = StRun;
            StRun:  if (cnt_q == CntLast) state_d = StCap;
            StCap:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        res_d        = res_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        mul_ld_d     = 1'b0;
        mul_a_d      = 4'd0;
        mul_b_d      = 4'd0;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    gnt_d        = grant_sel;
                    last_grant_d = grant_sel;
                    op_a_d       = grant_sel ? a1 : a0;
                    op_b_d       = grant_sel ? b1 : b0;
                    // Strobe and operands are registered so they appear in LOAD.
                    mul_ld_d     = 1'b1;
                    mul_a_d      = grant_sel ? a1 : a0;
                    mul_b_d      = grant_sel ? b1 : b0;
                end
            end
            StLoad: cnt_d = 4'd0;
            StRun:  cnt_d = cnt_q + 4'd1;
            StCap: begin
                res_d   = mul_y;
                done0_d = ~gnt_q;
                done1_d = gnt_q;
            end
            default: ;
        endcase
    end

    // Datapath registers; reset aborts any job without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_a_q       <= 4'd0;
            op_b_q       <= 4'd0;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            res_q        <= 8'd0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            mul_ld_q     <= 1'b0;
            mul_a_q      <= 4'd0;
            mul_b_q      <= 4'd0;
        end else begin
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            res_q        <= res_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            mul_ld_q     <= mul_ld_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
        end
    end

    always_comb begin
        busy   = (state_q != StIdle);
        done0  = done0_q;
        done1  = done1_q;
        res    = res_q;
        mul_ld = mul_ld_q;
        mul_a  = mul_a_q;
        mul_b  = mul_b_q;
    end

endmodule

// File: doc/mul_arbiter_ctrl.md
Name: mul_arbiter_ctrl

Overview:
- Sequences and shares one 4x4 shift-add multiplier between two requesters.
- Arbitrates round-robin and drives the multiplier's load strobe and operands.
- Waits a fixed number of iteration cycles, captures the 8-bit product, and returns it to the winning requester with a one-cycle done pulse.
- Sits between two client blocks and the multiplier datapath. The multiplier shares clk and rst with this block.

Parameters:
- MUL_CYCLES, default 4: clock edges after the load edge before mul_y holds the final product. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req0  in  1  requester 0 request; held high with a0/b0 stable until done0
- a0  in  4  requester 0 multiplicand
- b0  in  4  requester 0 multiplier
- req1  in  1  requester 1 request
- a1  in  4  requester 1 multiplicand
- b1  in  4  requester 1 multiplier
- done0  out  1  one-cycle pulse; res valid for requester 0
- done1  out  1  one-cycle pulse; res valid for requester 1
- res  out  8  captured product, held until next capture
- busy  out  1  high in every state except IDLE
- mul_ld  out  1  load strobe to multiplier
- mul_a  out  4  multiplicand to multiplier
- mul_b  out  4  multiplier operand to multiplier
- mul_y  in  8  multiplier product

Behaviour:
- Reset: rst is synchronous and active-low on clk.
  - rst=0 at a rising edge forces state=IDLE, done0=done1=0, res=0, op registers=0, cnt=0, last_grant=1 (requester 0 wins the first tie).
  - Reset mid-operation aborts the job: no done pulse, no capture.
- Outputs are registered: done0, done1, res, mul_ld, mul_a, mul_b.
  - mul_a/mul_b = 0 and mul_ld = 0 outside LOAD.
- States: IDLE, LOAD, RUN, CAP.
- IDLE, eligible requesters:
  - Eligible = reqN=1 AND doneN=0 in the current cycle. This masks a requester that is still holding req during its done cycle.
- IDLE, grant:
  - One eligible requester: grant it.
  - Both eligible: grant the one not equal to last_grant.
  - On the grant edge: latch its a/b into the op registers, set gnt and last_grant, go to LOAD.
  - None eligible: stay in IDLE.
- LOAD (1 cycle):
  - mul_ld=1, mul_a/mul_b = latched ops.
  - Next edge: cnt<=0, go to RUN.
- RUN:
  - cnt increments each edge.
  - After MUL_CYCLES RUN cycles (cnt==MUL_CYCLES-1 at the edge), go to CAP.
- CAP (1 cycle):
  - mul_y is final. At the edge: res<=mul_y, done[gnt]<=1, go to IDLE.
- done pulse:
  - done is high exactly one cycle, the first IDLE cycle after CAP; cleared at the following edge.
  - Requester drops req in the done cycle or later. A req still high after the done cycle is a new request.
- Latency (MUL_CYCLES=4):
  - req first sampled high in IDLE cycle c0 → LOAD c1 → RUN c2..c5 → CAP c6 → done high c7.
  - Total 7 cycles; general formula MUL_CYCLES+3.
- Back-to-back:
  - Arbitration runs in the done cycle itself. The other requester's LOAD can occur at c8.
  - Service period per job is MUL_CYCLES+3 cycles.
- Requests that drop while not granted are simply not served.
- Requests that drop while granted do not abort the job. The job completes and done still pulses.
- Arithmetic: product is unsigned 4x4→8 bits; no overflow possible. res is taken verbatim from mul_y.
- busy = (state != IDLE), combinational from the state register.

Test Plan:
- Reset, then req0=1, a0=3, b0=5 held → mul_ld high in cycle c1 with mul_a=3, mul_b=5; done0 pulses in c7 with res=15; done1 stays 0; busy high c1..c6.
- After reset, req0 (a0=15, b0=15) and req1 (a1=7, b1=9) rise in the same cycle → requester 0 served first: done0 at c7, res=225. Requester 1 LOAD at c8, done1 at c14, res=63.
- req0 and req1 held high continuously, operands 2x3 and 4x4 → done pulses alternate 0,1,0,1 every 7 cycles with res 6,16,6,16. Neither requester is granted twice in a row.
- Boundary operands, one at a time → 0x13 gives res=0; 15x0 gives res=0; 1x15 gives res=15; 15x15 gives res=225.
- Assert rst=0 for one cycle during RUN (cycle c3) of a 9x9 job → next cycle state IDLE, busy=0, res=0, no done pulse. A re-request then completes with res=81 after 7 cycles.
- req0 held high across its own done cycle while req1=0 → no grant in the done cycle. A new job starts only if req0 is still high in the cycle after done.
